// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target receiver and the master.
// Contents: FSM state encoding, R/W bit values, ACK/NACK bit values.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StDevAck,
        StRegAddr,
        StRegAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StIgnore
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Input synchroniser and bus-event detector for SCL/SDA.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   scl_raw, sda_raw  asynchronous bus inputs
//   sda_sync          synchronised SDA (aligned with the edge flags)
//   scl_rise/scl_fall one-cycle SCL edge flags
//   start/stop        one-cycle START (SDA fall, SCL high) / STOP (SDA rise, SCL high)
// SYNC_STAGES must be at least 2.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_now;

    // Pipes reset to the idle bus level so reset release creates no false events.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_raw};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_raw};
            scl_prev <= scl_pipe[SYNC_STAGES-1];
            sda_prev <= sda_pipe[SYNC_STAGES-1];
        end
    end

    assign scl_now  = scl_pipe[SYNC_STAGES-1];
    assign sda_sync = sda_pipe[SYNC_STAGES-1];
    assign scl_rise = scl_now & ~scl_prev;
    assign scl_fall = ~scl_now & scl_prev;
    // SCL must be high on both sides of the SDA transition.
    assign start    = scl_now & scl_prev & sda_prev & ~sda_sync;
    assign stop     = scl_now & scl_prev & ~sda_prev & sda_sync;

endmodule

// File: rtl/i2c_slave_rx.sv
// Oversampled I2C target: decodes START/STOP, matches DEV_ADDR, ACKs, and
// issues one write strobe per data byte with an auto-incrementing pointer.
// Ports:
//   clk, rst            system clock (>= 8x SCL), synchronous active-high reset
//   i_scl, io_sda       I2C bus; SDA is only ever pulled low or released
//   o_sda_mode          1 while the target pulls SDA low
//   o_wr_en/addr/data   one-cycle register write strobe
//   o_rd_addr/i_rd_data read port (read build only; o_rd_addr is 0 otherwise)
//   o_busy              high between START and STOP
//   o_nack_flag         one-cycle pulse on device-address rejection
// Optional feature macro: I2C_SLAVE_READ_EN (enables read transfers).
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic       o_sda_mode,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic [7:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    output logic       o_busy,
    output logic       o_nack_flag
);

    i2c_state_e state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] pointer;
    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;
    logic       byte_done;
    logic       addr_match;
    logic       rw_ok;

    i2c_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .scl_raw (i_scl),
        .sda_raw (io_sda),
        .sda_sync(sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    assign io_sda     = o_sda_mode ? 1'b0 : 1'bz;
    assign byte_done  = scl_fall && (bit_cnt == 4'd8);
    assign addr_match = (shift[7:1] == DEV_ADDR);

`ifdef I2C_SLAVE_READ_EN
    logic       rd_mode;
    logic [7:0] rd_shift;
    assign rw_ok     = 1'b1;
    assign o_rd_addr = pointer;
`else
    logic unused_rd;
    assign rw_ok     = (shift[0] == I2C_RW_WRITE);
    assign o_rd_addr = 8'h00;
    assign unused_rd = ^i_rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            bit_cnt     <= 4'd0;
            shift       <= 8'h00;
            pointer     <= 8'h00;
            o_sda_mode  <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= 8'h00;
            o_wr_data   <= 8'h00;
            o_busy      <= 1'b0;
            o_nack_flag <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            rd_mode     <= 1'b0;
            rd_shift    <= 8'h00;
`endif
        end else begin
            o_wr_en     <= 1'b0;
            o_nack_flag <= 1'b0;
            if (start) begin
                state      <= StDevAddr;
                bit_cnt    <= 4'd0;
                o_sda_mode <= 1'b0;
                o_busy     <= 1'b1;
            end else if (stop) begin
                state      <= StIdle;
                bit_cnt    <= 4'd0;
                o_sda_mode <= 1'b0;
                o_busy     <= 1'b0;
            end else begin
                // Bit counter saturates at 8; it is cleared on each ACK-phase SCL fall.
                if (scl_rise && bit_cnt != 4'd8) begin
                    shift   <= {shift[6:0], sda};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    StDevAddr: begin
                        if (byte_done) begin
                            if (addr_match && rw_ok) begin
                                state      <= StDevAck;
                                o_sda_mode <= 1'b1;
`ifdef I2C_SLAVE_READ_EN
                                rd_mode    <= (shift[0] == I2C_RW_READ);
`endif
                            end else begin
                                state       <= StIgnore;
                                o_nack_flag <= 1'b1;
                            end
                        end
                    end
                    StDevAck: begin
                        if (scl_fall) begin
                            bit_cnt    <= 4'd0;
                            o_sda_mode <= 1'b0;
                            state      <= StRegAddr;
`ifdef I2C_SLAVE_READ_EN
                            if (rd_mode) begin
                                state      <= StRdData;
                                rd_shift   <= i_rd_data;
                                o_sda_mode <= ~i_rd_data[7];
                            end
`endif
                        end
                    end
                    StRegAddr: begin
                        if (byte_done) begin
                            pointer    <= shift;
                            state      <= StRegAck;
                            o_sda_mode <= 1'b1;
                        end
                    end
                    StRegAck, StWrAck: begin
                        if (scl_fall) begin
                            bit_cnt    <= 4'd0;
                            o_sda_mode <= 1'b0;
                            state      <= StWrData;
                        end
                    end
                    StWrData: begin
                        if (scl_rise && bit_cnt == 4'd7) begin
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= pointer;
                            o_wr_data <= {shift[6:0], sda};
                        end
                        if (byte_done) begin
                            pointer    <= pointer + 8'd1;
                            state      <= StWrAck;
                            o_sda_mode <= 1'b1;
                        end
                    end
`ifdef I2C_SLAVE_READ_EN
                    StRdData: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                o_sda_mode <= 1'b0;
                                state      <= StRdAck;
                            end else if (bit_cnt != 4'd0) begin
                                rd_shift   <= {rd_shift[6:0], 1'b0};
                                o_sda_mode <= ~rd_shift[6];
                            end
                        end
                    end
                    StRdAck: begin
                        // Pointer advances on the ACK rise so the reload at the fall sees new data.
                        if (scl_rise) begin
                            if (sda == I2C_ACK) begin
                                pointer <= pointer + 8'd1;
                            end else begin
                                state <= StIgnore;
                            end
                        end else if (scl_fall) begin
                            bit_cnt    <= 4'd0;
                            state      <= StRdData;
                            rd_shift   <= i_rd_data;
                            o_sda_mode <= ~i_rd_data[7];
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
module tb_i2c_slave_rx;

    localparam int Q = 6;  // system clocks per quarter SCL period

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       scl       = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda_bus;
    logic       o_sda_mode;
    logic       o_wr_en;
    logic [7:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic [7:0] o_rd_addr;
    logic [7:0] i_rd_data;
    logic       o_busy;
    logic       o_nack_flag;

    always #5 clk = ~clk;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always_comb begin
        case (o_rd_addr)
            8'h20:   i_rd_data = 8'hC3;
            8'h21:   i_rd_data = 8'h3C;
            default: i_rd_data = ~o_rd_addr;
        endcase
    end

    i2c_slave_rx #(
        .DEV_ADDR   (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (scl),
        .io_sda     (sda_bus),
        .o_sda_mode (o_sda_mode),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .o_busy     (o_busy),
        .o_nack_flag(o_nack_flag)
    );

    // Strobe and NACK-pulse monitor.
    logic [15:0] strobe_q [$];
    int          nack_cnt = 0;
    always @(negedge clk) begin
        if (o_wr_en) strobe_q.push_back({o_wr_addr, o_wr_data});
        if (o_nack_flag) nack_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bus master ----------------
    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        m_sda_low = 1'b0; quarter();
        scl = 1'b1;       quarter();
        m_sda_low = 1'b1; quarter();
        scl = 1'b0;       quarter();
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; quarter();
        scl = 1'b1;       quarter();
        m_sda_low = 1'b0; quarter();
        quarter();
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = !b; quarter();
        scl = 1'b1;     quarter(); quarter();
        scl = 1'b0;     quarter();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, output logic drv);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda_low = 1'b0; quarter();
        scl = 1'b1;       quarter();
        ack = (sda_bus === 1'b0);
        drv = o_sda_mode;
        quarter();
        scl = 1'b0;       quarter();
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic [7:0] v;
        v = 8'h00;
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            quarter();
            scl = 1'b1; quarter();
            v[i] = (sda_bus !== 1'b0);
            quarter();
            scl = 1'b0;
        end
        quarter();
        m_sda_low = !nack; quarter();
        scl = 1'b1;        quarter(); quarter();
        scl = 1'b0;        quarter();
        m_sda_low = 1'b0;
        d = v;
    endtask

    // ---------------- frame runner, model, compare ----------------
    logic [7:0]  tx_bytes [8];
    int          tx_n;
    logic        got_dev_ack;
    logic        got_acks [8];
    logic        exp_dev_ack;
    logic [15:0] exp_q [$];
    int          exp_nacks;
    int          nack_base;

    task automatic run_frame(input logic [6:0] dev, input logic rw);
        logic a, drv;
        strobe_q.delete();
        nack_base = nack_cnt;
        m_start();
        send_byte({dev, rw}, got_dev_ack, drv);
        check("busy_in_frame", 32'(o_busy), 32'(1'b1));
        check("dev_ack_drive", 32'(drv), 32'(exp_dev_ack));
        for (int i = 0; i < tx_n; i++) begin
            send_byte(tx_bytes[i], a, drv);
            got_acks[i] = a;
        end
        m_stop();
        check("busy_after_stop", 32'(o_busy), 32'(1'b0));
        check("sda_released_after_stop", 32'(o_sda_mode), 32'(1'b0));
    endtask

    // Reference: first data byte sets the pointer, each further byte is a write at pointer++.
    task automatic model(input logic [6:0] dev, input logic rw);
        exp_q.delete();
        exp_dev_ack = (dev == 7'h50) && (rw == 1'b0);
        exp_nacks   = exp_dev_ack ? 0 : 1;
        if (exp_dev_ack) begin
            for (int i = 1; i < tx_n; i++) begin
                exp_q.push_back({8'(tx_bytes[0] + 8'(i - 1)), tx_bytes[i]});
            end
        end
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_dev_ack"}, 32'(got_dev_ack), 32'(exp_dev_ack));
        for (int i = 0; i < tx_n; i++)
            check($sformatf("%s_byte%0d_ack", tag, i), 32'(got_acks[i]), 32'(exp_dev_ack));
        check({tag, "_strobe_count"}, 32'(strobe_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < strobe_q.size(); i++)
            check($sformatf("%s_strobe%0d", tag, i), 32'(strobe_q[i]), 32'(exp_q[i]));
        check({tag, "_nack_pulses"}, 32'(nack_cnt - nack_base), 32'(exp_nacks));
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [6:0]        dev;
        logic              rw;
        logic [2:0]        n;
        logic [0:3][7:0]   bytes;
        logic              dev_ack;
        logic [1:0]        n_strobe;
        logic [0:2][15:0]  strobes;
        logic [1:0]        nacks;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] dev, input logic rw, input logic [2:0] n,
                                input logic [31:0] bytes, input logic dev_ack,
                                input logic [1:0] ns, input logic [47:0] strobes,
                                input logic [1:0] nacks);
        vec_t v;
        v.dev = dev; v.rw = rw; v.n = n; v.bytes = bytes; v.dev_ack = dev_ack;
        v.n_strobe = ns; v.strobes = strobes; v.nacks = nacks;
        return v;
    endfunction

    vec_t vecs [6];
    int   nvec;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic       a, drv;
        logic [7:0] d;
        logic [6:0] dev;

        vecs[0] = mk(7'h50, 1'b0, 3'd2, {8'h12, 8'hA5, 8'h00, 8'h00}, 1'b1, 2'd1,
                     {16'h12A5, 16'h0000, 16'h0000}, 2'd0);
        vecs[1] = mk(7'h51, 1'b0, 3'd1, {8'h12, 8'h00, 8'h00, 8'h00}, 1'b0, 2'd0, 48'h0, 2'd1);
        vecs[2] = mk(7'h50, 1'b0, 3'd4, {8'hFE, 8'h11, 8'h22, 8'h33}, 1'b1, 2'd3,
                     {16'hFE11, 16'hFF22, 16'h0033}, 2'd0);
        vecs[3] = mk(7'h50, 1'b0, 3'd1, {8'h7F, 8'h00, 8'h00, 8'h00}, 1'b1, 2'd0, 48'h0, 2'd0);
        vecs[4] = mk(7'h10, 1'b0, 3'd2, {8'h05, 8'h06, 8'h00, 8'h00}, 1'b0, 2'd0, 48'h0, 2'd1);
        nvec = 5;
`ifndef I2C_SLAVE_READ_EN
        vecs[5] = mk(7'h50, 1'b1, 3'd0, 32'h0, 1'b0, 2'd0, 48'h0, 2'd1);
        nvec = 6;
`endif

        // Reset state.
        repeat (5) @(negedge clk);
        check("rst_sda_mode", 32'(o_sda_mode), 32'(1'b0));
        check("rst_wr_en", 32'(o_wr_en), 32'(1'b0));
        check("rst_wr_addr", 32'(o_wr_addr), 32'(8'h00));
        check("rst_wr_data", 32'(o_wr_data), 32'(8'h00));
        check("rst_rd_addr", 32'(o_rd_addr), 32'(8'h00));
        check("rst_busy", 32'(o_busy), 32'(1'b0));
        check("rst_nack", 32'(o_nack_flag), 32'(1'b0));
        check("rst_bus_released", 32'(sda_bus === 1'b1), 32'(1'b1));
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Table vectors.
        for (int i = 0; i < nvec; i++) begin
            tx_n = int'(vecs[i].n);
            for (int j = 0; j < 4; j++) tx_bytes[j] = vecs[i].bytes[j];
            exp_dev_ack = vecs[i].dev_ack;
            exp_nacks   = int'(vecs[i].nacks);
            exp_q.delete();
            for (int j = 0; j < int'(vecs[i].n_strobe); j++) exp_q.push_back(vecs[i].strobes[j]);
            run_frame(vecs[i].dev, vecs[i].rw);
            compare_frame($sformatf("vec%0d", i));
        end

        // Randomised write frames against the reference model.
        for (int t = 0; t < 16; t++) begin
            dev  = ($urandom_range(0, 3) != 0) ? 7'h50 : 7'($urandom);
            tx_n = int'($urandom_range(0, 4));
            for (int j = 0; j < 8; j++) tx_bytes[j] = 8'($urandom);
            model(dev, 1'b0);
            run_frame(dev, 1'b0);
            compare_frame($sformatf("rand%0d", t));
        end

        // STOP after 4 bits of a data byte: no strobe, bus released.
        strobe_q.delete();
        m_start();
        send_byte(8'hA0, a, drv);
        send_byte(8'h30, a, drv);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        m_stop();
        check("early_stop_strobes", 32'(strobe_q.size()), 32'd0);
        check("early_stop_busy", 32'(o_busy), 32'(1'b0));
        check("early_stop_sda", 32'(o_sda_mode), 32'(1'b0));

        // Repeated START after the reg byte, then a fresh write.
        strobe_q.delete();
        m_start();
        send_byte(8'hA0, a, drv);
        send_byte(8'h77, a, drv);
        m_start();
        send_byte(8'hA0, a, drv);
        check("rstart_dev_ack", 32'(a), 32'(1'b1));
        send_byte(8'h40, a, drv);
        send_byte(8'h5A, a, drv);
        m_stop();
        check("rstart_strobe_count", 32'(strobe_q.size()), 32'd1);
        if (strobe_q.size() > 0) check("rstart_strobe", 32'(strobe_q[0]), 32'h405A);

        // SDA glitch (START) mid data byte discards the partial byte.
        strobe_q.delete();
        m_start();
        send_byte(8'hA0, a, drv);
        send_byte(8'h60, a, drv);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        m_start();
        m_stop();
        check("glitch_strobes", 32'(strobe_q.size()), 32'd0);

        // Reset mid-byte clears every output on the next cycle.
        m_start();
        send_byte(8'hA0, a, drv);
        send_byte(8'h12, a, drv);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("pre_rst_busy", 32'(o_busy), 32'(1'b1));
        check("pre_rst_wr_addr", 32'(o_wr_addr), 32'(8'h40));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(o_busy), 32'(1'b0));
        check("mid_rst_sda_mode", 32'(o_sda_mode), 32'(1'b0));
        check("mid_rst_wr_en", 32'(o_wr_en), 32'(1'b0));
        check("mid_rst_wr_addr", 32'(o_wr_addr), 32'(8'h00));
        check("mid_rst_wr_data", 32'(o_wr_data), 32'(8'h00));
        check("mid_rst_nack", 32'(o_nack_flag), 32'(1'b0));
        check("mid_rst_rd_addr", 32'(o_rd_addr), 32'(8'h00));
        rst = 1'b0;
        repeat (4) @(negedge clk);
        m_stop();

`ifdef I2C_SLAVE_READ_EN
        // Set pointer to 0x20, repeated START, read two bytes, NACK the last.
        strobe_q.delete();
        m_start();
        send_byte(8'hA0, a, drv);
        send_byte(8'h20, a, drv);
        m_start();
        send_byte(8'hA1, a, drv);
        check("rd_dev_ack", 32'(a), 32'(1'b1));
        read_byte(d, 1'b0);
        check("rd_byte0", 32'(d), 32'(8'hC3));
        read_byte(d, 1'b1);
        check("rd_byte1", 32'(d), 32'(8'h3C));
        quarter();
        check("rd_nack_released", 32'(o_sda_mode), 32'(1'b0));
        check("rd_addr_final", 32'(o_rd_addr), 32'(8'h21));
        m_stop();
        check("rd_busy_after_stop", 32'(o_busy), 32'(1'b0));
        check("rd_no_strobes", 32'(strobe_q.size()), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
